// File: rtl/axi_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : axi_write_scheduler
//  Description : Shares one AXI4 master write path (AW/W/B) among several
//                cache-side requesters. AW is round-robin arbitrated with a
//                grant lock and per-port outstanding limits, W is ordered by
//                AW grant through a small port FIFO, and B is routed back by
//                a port tag prepended to the AXI ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_write_scheduler #(
    parameter  int NUM_PORTS       = 3,
    parameter  int ID_WIDTH        = 4,
    parameter  int AW_DATA_WIDTH   = 64,
    parameter  int W_DATA_WIDTH    = 73,
    parameter  int FIFO_DEPTH      = 4,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int PORT_W          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    // requester side
    input  logic [NUM_PORTS-1:0]              req_aw_valid_i,
    output logic [NUM_PORTS-1:0]              req_aw_ready_o,
    input  logic [NUM_PORTS*ID_WIDTH-1:0]     req_aw_id_i,
    input  logic [NUM_PORTS*AW_DATA_WIDTH-1:0] req_aw_data_i,
    input  logic [NUM_PORTS-1:0]              req_w_valid_i,
    output logic [NUM_PORTS-1:0]              req_w_ready_o,
    input  logic [NUM_PORTS-1:0]              req_w_last_i,
    input  logic [NUM_PORTS*W_DATA_WIDTH-1:0] req_w_data_i,
    output logic [NUM_PORTS-1:0]              req_b_valid_o,
    input  logic [NUM_PORTS-1:0]              req_b_ready_i,
    output logic [ID_WIDTH-1:0]               req_b_id_o,
    // master side
    output logic                              mst_aw_valid_o,
    input  logic                              mst_aw_ready_i,
    output logic [ID_WIDTH+PORT_W-1:0]        mst_aw_id_o,
    output logic [AW_DATA_WIDTH-1:0]          mst_aw_data_o,
    output logic                              mst_w_valid_o,
    input  logic                              mst_w_ready_i,
    output logic                              mst_w_last_o,
    output logic [W_DATA_WIDTH-1:0]           mst_w_data_o,
    input  logic                              mst_b_valid_i,
    output logic                              mst_b_ready_o,
    input  logic [ID_WIDTH+PORT_W-1:0]        mst_b_id_i,
    // status
    output logic                              busy_o,
    output logic                              err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0]  c_max_out     = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PORT_W:0]   c_num_ports   = (PORT_W+1)'(NUM_PORTS);
    localparam logic [PORT_W-1:0] c_last_port   = PORT_W'(NUM_PORTS - 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    // registered state
    logic [0:0]        r_state;
    logic [PORT_W-1:0] r_lock_port;
    logic [PORT_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0]  r_cnt [NUM_PORTS];
    logic [PORT_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic              r_err;

    // combinational
    logic [0:0]        w_state_nxt;
    logic [PORT_W-1:0] w_lock_port_nxt;
    logic [NUM_PORTS-1:0] w_eligible;
    logic              w_pick_found;
    logic [PORT_W-1:0] w_pick_port;
    logic [PORT_W:0]   w_scan;
    logic              w_grant_valid;
    logic [PORT_W-1:0] w_grant_port;
    logic [ID_WIDTH-1:0] w_aw_req_id;
    logic              w_aw_hs;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [PORT_W-1:0] w_fifo_head;
    logic              w_fifo_pop;
    logic [PORT_W-1:0] w_b_tag;
    logic              w_b_tag_ok;
    logic              w_b_hs;
    logic              w_any_cnt;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                          (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_fifo_head  = r_fifo[r_rd_ptr[PTR_W-1:0]];

    // A port may win AW only if it has room for another outstanding write
    // and the W-order FIFO can record the grant.
    always_comb begin
        w_eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_eligible[p] = req_aw_valid_i[p] && (r_cnt[p] < c_max_out) && !w_fifo_full;
        end
    end

    // Round-robin search: first eligible port at or after the pointer.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_port  = '0;
        w_scan       = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            w_scan = {1'b0, r_rr_ptr} + (PORT_W+1)'(off);
            if (w_scan >= c_num_ports) begin
                w_scan = w_scan - c_num_ports;
            end
            if (!w_pick_found && w_eligible[w_scan]) begin
                w_pick_found = 1'b1;
                w_pick_port  = w_scan[PORT_W-1:0];
            end
        end
    end

    // AW FSM next state and grant; a stalled grant is locked so the
    // master sees a stable valid/payload until it accepts.
    always_comb begin
        w_state_nxt     = r_state;
        w_lock_port_nxt = r_lock_port;
        w_grant_valid   = 1'b0;
        w_grant_port    = '0;
        case (r_state)
            S_IDLE: begin
                w_grant_valid = w_pick_found;
                w_grant_port  = w_pick_port;
                if (w_pick_found && !mst_aw_ready_i) begin
                    w_state_nxt     = S_LOCKED;
                    w_lock_port_nxt = w_pick_port;
                end
            end
            S_LOCKED: begin
                w_grant_valid = 1'b1;
                w_grant_port  = r_lock_port;
                if (mst_aw_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (rst_i) begin
            w_grant_valid = 1'b0;
        end
    end

    // AW FSM state register and lock holder.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_lock_port <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_port <= w_lock_port_nxt;
        end
    end

    // AW payload mux and per-port ready.
    always_comb begin
        mst_aw_data_o  = '0;
        w_aw_req_id    = '0;
        req_aw_ready_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_grant_port == PORT_W'(p)) begin
                mst_aw_data_o     = req_aw_data_i[p*AW_DATA_WIDTH +: AW_DATA_WIDTH];
                w_aw_req_id       = req_aw_id_i[p*ID_WIDTH +: ID_WIDTH];
                req_aw_ready_o[p] = w_grant_valid && mst_aw_ready_i;
            end
        end
    end

    assign mst_aw_valid_o = w_grant_valid;
    assign mst_aw_id_o    = {w_grant_port, w_aw_req_id};
    assign w_aw_hs        = w_grant_valid && mst_aw_ready_i;

    // Round-robin pointer moves past the port that just completed AW.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
        end else if (w_aw_hs) begin
            r_rr_ptr <= (w_grant_port == c_last_port) ? '0 : w_grant_port + 1'b1;
        end
    end

    // W mux follows the FIFO head; only the head port sees ready.
    always_comb begin
        mst_w_valid_o = 1'b0;
        mst_w_last_o  = 1'b0;
        mst_w_data_o  = '0;
        req_w_ready_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_fifo_head == PORT_W'(p)) begin
                mst_w_valid_o    = !w_fifo_empty && req_w_valid_i[p] && !rst_i;
                mst_w_last_o     = req_w_last_i[p];
                mst_w_data_o     = req_w_data_i[p*W_DATA_WIDTH +: W_DATA_WIDTH];
                req_w_ready_o[p] = !w_fifo_empty && mst_w_ready_i && !rst_i;
            end
        end
    end

    assign w_fifo_pop = mst_w_valid_o && mst_w_ready_i && mst_w_last_o;

    // W-order FIFO: push grant on AW handshake, pop on the last W beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_aw_hs) begin
                r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_grant_port;
                r_wr_ptr                    <= r_wr_ptr + 1'b1;
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign w_b_tag    = mst_b_id_i[ID_WIDTH +: PORT_W];
    assign w_b_tag_ok = ({1'b0, w_b_tag} < c_num_ports);
    assign req_b_id_o = mst_b_id_i[ID_WIDTH-1:0];

    // B routing by tag; an unknown tag is absorbed by the scheduler.
    always_comb begin
        req_b_valid_o = '0;
        mst_b_ready_o = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_b_tag == PORT_W'(p)) begin
                req_b_valid_o[p] = mst_b_valid_i;
                mst_b_ready_o    = req_b_ready_i[p];
            end
        end
        if (rst_i) begin
            req_b_valid_o = '0;
            mst_b_ready_o = 1'b0;
        end
    end

    assign w_b_hs = mst_b_valid_i && mst_b_ready_o;

    // Outstanding counters: AW increments, B decrements (saturating at 0);
    // both on the same port in one cycle cancel out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if ((w_aw_hs && (w_grant_port == PORT_W'(p))) &&
                    !(w_b_hs && w_b_tag_ok && (w_b_tag == PORT_W'(p)) && (r_cnt[p] != '0))) begin
                    r_cnt[p] <= r_cnt[p] + 1'b1;
                end else if (!(w_aw_hs && (w_grant_port == PORT_W'(p))) &&
                             (w_b_hs && w_b_tag_ok && (w_b_tag == PORT_W'(p)) && (r_cnt[p] != '0))) begin
                    r_cnt[p] <= r_cnt[p] - 1'b1;
                end
            end
        end
    end

    // Sticky error on a response carrying a tag no requester owns.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (mst_b_valid_i && !w_b_tag_ok) begin
            r_err <= 1'b1;
        end
    end

    // Busy whenever any write is unanswered or still owes W data.
    always_comb begin
        w_any_cnt = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_any_cnt = w_any_cnt | (r_cnt[p] != '0);
        end
    end

    assign busy_o = !rst_i && (w_any_cnt || !w_fifo_empty);
    assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_write_scheduler
//  Description : Directed self-checking bench for axi_write_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_write_scheduler;

    logic        clk;
    logic        rst;
    logic [2:0]  aw_valid;
    logic [2:0]  aw_ready;
    logic [3:0]  aw_id   [3];
    logic [63:0] aw_data [3];
    logic [2:0]  w_valid;
    logic [2:0]  w_ready;
    logic [2:0]  w_last;
    logic [72:0] w_data  [3];
    logic [2:0]  b_valid;
    logic [2:0]  b_ready;
    logic [3:0]  b_id;
    logic        m_aw_valid;
    logic        m_aw_ready;
    logic [5:0]  m_aw_id;
    logic [63:0] m_aw_data;
    logic        m_w_valid;
    logic        m_w_ready;
    logic        m_w_last;
    logic [72:0] m_w_data;
    logic        m_b_valid;
    logic        m_b_ready;
    logic [5:0]  m_b_id;
    logic        busy;
    logic        err;

    logic [11:0]  aw_id_bus;
    logic [191:0] aw_data_bus;
    logic [218:0] w_data_bus;

    int total;
    int bad;

    assign aw_id_bus   = {aw_id[2], aw_id[1], aw_id[0]};
    assign aw_data_bus = {aw_data[2], aw_data[1], aw_data[0]};
    assign w_data_bus  = {w_data[2], w_data[1], w_data[0]};

    axi_write_scheduler dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_aw_valid_i (aw_valid),
        .req_aw_ready_o (aw_ready),
        .req_aw_id_i    (aw_id_bus),
        .req_aw_data_i  (aw_data_bus),
        .req_w_valid_i  (w_valid),
        .req_w_ready_o  (w_ready),
        .req_w_last_i   (w_last),
        .req_w_data_i   (w_data_bus),
        .req_b_valid_o  (b_valid),
        .req_b_ready_i  (b_ready),
        .req_b_id_o     (b_id),
        .mst_aw_valid_o (m_aw_valid),
        .mst_aw_ready_i (m_aw_ready),
        .mst_aw_id_o    (m_aw_id),
        .mst_aw_data_o  (m_aw_data),
        .mst_w_valid_o  (m_w_valid),
        .mst_w_ready_i  (m_w_ready),
        .mst_w_last_o   (m_w_last),
        .mst_w_data_o   (m_w_data),
        .mst_b_valid_i  (m_b_valid),
        .mst_b_ready_o  (m_b_ready),
        .mst_b_id_i     (m_b_id),
        .busy_o         (busy),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One W beat expected from the head port, then advance a cycle.
    task automatic w_beat(input string tag, input logic [2:0] exp_rdy,
                          input logic [72:0] exp_data, input logic exp_last);
        #1;
        chk({tag, "_wvld"}, 128'(m_w_valid), 128'(1'b1));
        chk({tag, "_wrdy"}, 128'(w_ready), 128'(exp_rdy));
        chk({tag, "_wdat"}, 128'(m_w_data), 128'(exp_data));
        chk({tag, "_wlst"}, 128'(m_w_last), 128'(exp_last));
        step();
    endtask

    // One B response from the master, checked on the requester side.
    task automatic b_rsp(input string tag, input logic [5:0] id,
                         input logic [2:0] exp_vld, input logic [3:0] exp_id);
        m_b_valid = 1'b1;
        m_b_id    = id;
        #1;
        chk({tag, "_bvld"}, 128'(b_valid), 128'(exp_vld));
        chk({tag, "_bid"},  128'(b_id), 128'(exp_id));
        chk({tag, "_brdy"}, 128'(m_b_ready), 128'(1'b1));
        step();
        m_b_valid = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        aw_valid   = 3'b000;
        w_valid    = 3'b000;
        w_last     = 3'b000;
        b_ready    = 3'b000;
        m_aw_ready = 1'b0;
        m_w_ready  = 1'b0;
        m_b_valid  = 1'b0;
        m_b_id     = 6'h00;
        for (int i = 0; i < 3; i++) begin
            aw_id[i]   = 4'h0;
            aw_data[i] = 64'h0;
            w_data[i]  = 73'(32'h100 + i);
        end

        // ---- reset: requests present but everything held quiet ----
        aw_id[0] = 4'h1; aw_id[1] = 4'h2; aw_id[2] = 4'h3;
        aw_data[0] = 64'hA0A0; aw_data[1] = 64'hA1A1; aw_data[2] = 64'hA2A2;
        aw_valid   = 3'b111;
        m_aw_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awvld", 128'(m_aw_valid), 128'(1'b0));
        chk("rst_awrdy", 128'(aw_ready), 128'(3'b000));
        chk("rst_wvld",  128'(m_w_valid), 128'(1'b0));
        chk("rst_brdy",  128'(m_b_ready), 128'(1'b0));
        chk("rst_busy",  128'(busy), 128'(1'b0));
        chk("rst_err",   128'(err), 128'(1'b0));
        rst = 1'b0;

        // ---- test 1: three simultaneous requests granted 0,1,2 ----
        #1;
        chk("t1_g0_vld", 128'(m_aw_valid), 128'(1'b1));
        chk("t1_g0_id",  128'(m_aw_id), 128'(6'h01));
        chk("t1_g0_dat", 128'(m_aw_data), 128'(64'hA0A0));
        chk("t1_g0_rdy", 128'(aw_ready), 128'(3'b001));
        step();
        aw_valid = 3'b110;
        #1;
        chk("t1_g1_id",  128'(m_aw_id), 128'(6'h12));
        chk("t1_g1_rdy", 128'(aw_ready), 128'(3'b010));
        step();
        aw_valid = 3'b100;
        #1;
        chk("t1_g2_id",  128'(m_aw_id), 128'(6'h23));
        chk("t1_g2_rdy", 128'(aw_ready), 128'(3'b100));
        step();
        aw_valid = 3'b000;
        #1;
        chk("t1_idle_vld", 128'(m_aw_valid), 128'(1'b0));
        chk("t1_busy",     128'(busy), 128'(1'b1));
        w_valid = 3'b111; w_last = 3'b111; m_w_ready = 1'b1;
        w_beat("t1_w0", 3'b001, 73'h100, 1'b1);
        w_beat("t1_w1", 3'b010, 73'h101, 1'b1);
        w_beat("t1_w2", 3'b100, 73'h102, 1'b1);
        chk("t1_wempty", 128'(m_w_valid), 128'(1'b0));
        w_valid = 3'b000;
        b_ready = 3'b111;
        b_rsp("t1_b0", 6'h01, 3'b001, 4'h1);
        b_rsp("t1_b1", 6'h12, 3'b010, 4'h2);
        b_rsp("t1_b2", 6'h23, 3'b100, 4'h3);
        #1;
        chk("t1_idle_busy", 128'(busy), 128'(1'b0));
        // a response for a port with nothing outstanding must not wrap its count
        b_rsp("t1_bsat", 6'h01, 3'b001, 4'h1);
        #1;
        chk("t1_sat_busy", 128'(busy), 128'(1'b0));

        // ---- test 2: stalled grant is locked, others wait ----
        aw_id[1] = 4'h5; aw_data[1] = 64'h1111;
        aw_id[2] = 4'h6; aw_data[2] = 64'h2222;
        aw_id[0] = 4'h7; aw_data[0] = 64'h0707;
        aw_valid   = 3'b110;
        m_aw_ready = 1'b0;
        #1;
        chk("t2_c0_id",  128'(m_aw_id), 128'(6'h15));
        chk("t2_c0_rdy", 128'(aw_ready), 128'(3'b000));
        step();
        aw_valid = 3'b111;
        #1;
        chk("t2_c1_id",  128'(m_aw_id), 128'(6'h15));
        chk("t2_c1_dat", 128'(m_aw_data), 128'(64'h1111));
        step();
        #1;
        chk("t2_c2_id",  128'(m_aw_id), 128'(6'h15));
        chk("t2_c2_vld", 128'(m_aw_valid), 128'(1'b1));
        step();
        m_aw_ready = 1'b1;
        #1;
        chk("t2_hs_id",  128'(m_aw_id), 128'(6'h15));
        chk("t2_hs_rdy", 128'(aw_ready), 128'(3'b010));
        step();
        aw_valid = 3'b101;
        #1;
        chk("t2_p2_id",  128'(m_aw_id), 128'(6'h26));
        chk("t2_p2_rdy", 128'(aw_ready), 128'(3'b100));
        step();
        aw_valid = 3'b001;
        #1;
        chk("t2_p0_id",  128'(m_aw_id), 128'(6'h07));
        step();
        aw_valid = 3'b000;
        w_valid = 3'b111; w_last = 3'b111;
        w_beat("t2_w1", 3'b010, 73'h101, 1'b1);
        w_beat("t2_w2", 3'b100, 73'h102, 1'b1);
        w_beat("t2_w0", 3'b001, 73'h100, 1'b1);
        w_valid = 3'b000;
        b_rsp("t2_b1", 6'h15, 3'b010, 4'h5);
        b_rsp("t2_b2", 6'h26, 3'b100, 4'h6);
        b_rsp("t2_b0", 6'h07, 3'b001, 4'h7);

        // ---- test 3: W ordered by AW grant, no fall-through ----
        m_w_ready = 1'b0;
        w_valid = 3'b010; w_last = 3'b010;
        w_data[1] = 73'h1BB;
        aw_id[2] = 4'hA; aw_id[1] = 4'hB;
        aw_valid = 3'b100;
        #1;
        chk("t3_aw2_id",   128'(m_aw_id), 128'(6'h2A));
        chk("t3_nofall",   128'(m_w_valid), 128'(1'b0));
        step();
        aw_valid = 3'b010;
        #1;
        chk("t3_aw1_id",   128'(m_aw_id), 128'(6'h1B));
        chk("t3_headwait", 128'(m_w_valid), 128'(1'b0));
        step();
        aw_valid  = 3'b000;
        w_valid   = 3'b110;
        m_w_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            w_data[2] = 73'(32'h200 + b);
            w_last[2] = (b == 3);
            w_beat("t3_p2", 3'b100, 73'(32'h200 + b), (b == 3));
        end
        w_beat("t3_p1", 3'b010, 73'h1BB, 1'b1);
        chk("t3_wempty", 128'(m_w_valid), 128'(1'b0));
        w_valid = 3'b000;
        b_rsp("t3_b2", 6'h2A, 3'b100, 4'hA);
        b_rsp("t3_b1", 6'h1B, 3'b010, 4'hB);

        // ---- test 4: outstanding limit on port 1 ----
        aw_id[1] = 4'h9;
        aw_valid = 3'b010;
        #1;
        chk("t4_a1_id", 128'(m_aw_id), 128'(6'h19));
        step();
        #1;
        chk("t4_a2_id", 128'(m_aw_id), 128'(6'h19));
        step();
        #1;
        chk("t4_blk_vld", 128'(m_aw_valid), 128'(1'b0));
        chk("t4_blk_rdy", 128'(aw_ready), 128'(3'b000));
        step();
        m_b_valid = 1'b1;
        m_b_id    = 6'h19;
        #1;
        chk("t4_b_vld",   128'(b_valid), 128'(3'b010));
        chk("t4_b_id",    128'(b_id), 128'(4'h9));
        chk("t4_b_awvld", 128'(m_aw_valid), 128'(1'b0));
        step();
        m_b_valid = 1'b0;
        #1;
        chk("t4_a3_vld", 128'(m_aw_valid), 128'(1'b1));
        chk("t4_a3_rdy", 128'(aw_ready), 128'(3'b010));
        step();
        aw_valid = 3'b000;
        w_valid = 3'b010; w_last = 3'b010;
        w_beat("t4_w0", 3'b010, 73'h1BB, 1'b1);
        w_beat("t4_w1", 3'b010, 73'h1BB, 1'b1);
        w_beat("t4_w2", 3'b010, 73'h1BB, 1'b1);
        w_valid = 3'b000;
        b_rsp("t4_b1", 6'h19, 3'b010, 4'h9);
        b_rsp("t4_b2", 6'h19, 3'b010, 4'h9);
        #1;
        chk("t4_busy", 128'(busy), 128'(1'b0));

        // ---- test 5a: response with an unknown tag ----
        b_ready   = 3'b000;
        m_b_valid = 1'b1;
        m_b_id    = 6'h30;
        #1;
        chk("t5_brdy",  128'(m_b_ready), 128'(1'b1));
        chk("t5_bvld",  128'(b_valid), 128'(3'b000));
        chk("t5_err0",  128'(err), 128'(1'b0));
        step();
        m_b_valid = 1'b0;
        b_ready   = 3'b111;
        #1;
        chk("t5_err1", 128'(err), 128'(1'b1));
        step();
        #1;
        chk("t5_err2", 128'(err), 128'(1'b1));

        // ---- test 6: AW and B on port 0 in the same cycle ----
        aw_id[0] = 4'h4;
        aw_valid = 3'b001;
        step();
        m_b_valid = 1'b1;
        m_b_id    = 6'h04;
        #1;
        chk("t6_awrdy", 128'(aw_ready), 128'(3'b001));
        chk("t6_bvld",  128'(b_valid), 128'(3'b001));
        step();
        aw_valid  = 3'b000;
        m_b_valid = 1'b0;
        w_valid = 3'b001; w_last = 3'b001;
        w_beat("t6_w0", 3'b001, 73'h100, 1'b1);
        w_beat("t6_w1", 3'b001, 73'h100, 1'b1);
        w_valid = 3'b000;
        #1;
        chk("t6_busy_cnt1", 128'(busy), 128'(1'b1));
        b_rsp("t6_b", 6'h04, 3'b001, 4'h4);
        #1;
        chk("t6_busy_cnt0", 128'(busy), 128'(1'b0));

        // ---- test 5b: asynchronous reset in the middle of a burst ----
        aw_id[0] = 4'h1;
        aw_valid = 3'b001;
        step();
        aw_valid = 3'b000;
        w_valid = 3'b001; w_last = 3'b000;
        #1;
        chk("t5r_wvld", 128'(m_w_valid), 128'(1'b1));
        step();
        aw_valid  = 3'b111;
        m_b_valid = 1'b1;
        m_b_id    = 6'h01;
        #1;
        chk("t5r_busy_pre", 128'(busy), 128'(1'b1));
        #1;
        rst = 1'b1;
        #1;
        chk("t5r_awvld", 128'(m_aw_valid), 128'(1'b0));
        chk("t5r_awrdy", 128'(aw_ready), 128'(3'b000));
        chk("t5r_wvld0", 128'(m_w_valid), 128'(1'b0));
        chk("t5r_wrdy",  128'(w_ready), 128'(3'b000));
        chk("t5r_bvld",  128'(b_valid), 128'(3'b000));
        chk("t5r_brdy",  128'(m_b_ready), 128'(1'b0));
        chk("t5r_busy",  128'(busy), 128'(1'b0));
        chk("t5r_err",   128'(err), 128'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
